// File: rtl/ppu_compress.sv
// ppu_compress: ReLU/saturate, zero-run compress and lane-pack PE outputs.
// Optional build macro PPU_RELU_EN clamps negative inputs to zero.
module ppu_compress #(
  parameter int NUM_OUT = 4,
  parameter int ACC_W   = 32,
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 4,
  parameter int CNT_W   = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      acc_valid,
  input  logic signed [ACC_W-1:0]   acc_data,
  input  logic                      acc_last,
  output logic                      acc_ready,
  output logic [NUM_OUT-1:0]        out_valid,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT*IDX_W-1:0]  out_indices,
  output logic                      ppu_finish_en,
  output logic [CNT_W-1:0]          compressed_count
);

  localparam int PW  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int PW1 = PW + 1;
  localparam logic [IDX_W-1:0] MAXR = '1;
  localparam logic [PW-1:0] LASTSLOT = PW'(NUM_OUT - 1);
  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM,
    FLUSH,
    DONE
  } state_e;

  state_e state_q, state_d;
  logic [IDX_W-1:0] run_q, run_d;
  logic [PW-1:0] fill_q, fill_d;
  logic first_q, first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_OUT-1:0][DATA_W-1:0] bdat_q, bdat_d;
  logic [NUM_OUT-1:0][IDX_W-1:0] bidx_q, bidx_d;
  logic [NUM_OUT-1:0][DATA_W-1:0] odat_q, odat_d;
  logic [NUM_OUT-1:0][IDX_W-1:0] oidx_q, oidx_d;
  logic [NUM_OUT-1:0] oval_q, oval_d;

  logic accept;
  logic emit;
  logic zero;
  logic signed [ACC_W-1:0] relu_v;
  logic [DATA_W-1:0] sat_v;
  logic [PW1-1:0] nfill;
  logic [CNT_W-1:0] cbase;

  assign acc_ready = (state_q == ACCUM);
  assign accept    = acc_valid & acc_ready;

`ifdef PPU_RELU_EN
  assign relu_v = acc_data[ACC_W-1] ? '0 : acc_data;
`else
  assign relu_v = acc_data;
`endif

  always_comb begin
    if (relu_v > SMAX) begin
      sat_v = SMAX[DATA_W-1:0];
    end else if (relu_v < SMIN) begin
      sat_v = SMIN[DATA_W-1:0];
    end else begin
      sat_v = relu_v[DATA_W-1:0];
    end
  end

  assign zero = (sat_v == '0);
  assign emit = accept & (~zero | (run_q == MAXR));

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    fill_d  = fill_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    bdat_d  = bdat_q;
    bidx_d  = bidx_q;
    oval_d  = '0;
    odat_d  = '0;
    oidx_d  = '0;
    cbase   = first_q ? '0 : cnt_q;
    nfill   = {1'b0, fill_q} + PW1'(emit);
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (emit) begin
            bdat_d[fill_q] = sat_v;
            bidx_d[fill_q] = run_q;
          end
          run_d   = emit ? '0 : run_q + IDX_W'(1);
          fill_d  = fill_q + PW'(emit);
          first_d = acc_last;
          if (emit && (cbase != '1)) begin
            cnt_d = cbase + CNT_W'(1);
          end else begin
            cnt_d = cbase;
          end
          if (acc_last || (emit && (fill_q == LASTSLOT))) begin
            for (int i = 0; i < NUM_OUT; i++) begin
              if (PW1'(i) < nfill) begin
                oval_d[i] = 1'b1;
                odat_d[i] = bdat_d[i];
                oidx_d[i] = bidx_d[i];
              end
            end
            fill_d = '0;
          end
          if (acc_last) begin
            run_d   = '0;
            state_d = FLUSH;
          end
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      run_q   <= '0;
      fill_q  <= '0;
      first_q <= 1'b1;
      cnt_q   <= '0;
      bdat_q  <= '0;
      bidx_q  <= '0;
      oval_q  <= '0;
      odat_q  <= '0;
      oidx_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      fill_q  <= fill_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      bdat_q  <= bdat_d;
      bidx_q  <= bidx_d;
      oval_q  <= oval_d;
      odat_q  <= odat_d;
      oidx_q  <= oidx_d;
    end
  end

  assign out_valid        = oval_q;
  assign out_data         = odat_q;
  assign out_indices      = oidx_q;
  assign ppu_finish_en    = (state_q == DONE);
  assign compressed_count = cnt_q;

endmodule

// File: tb/tb_ppu_compress.sv
// tb_ppu_compress: scoreboard bench with directed and random planes
// against a queue-based compression model.
module tb_ppu_compress;

  localparam int NO   = 4;
  localparam int AW   = 32;
  localparam int DW   = 16;
  localparam int IW   = 4;
  localparam int CW   = 10;
  localparam int MAXR = (1 << IW) - 1;
  localparam int CMAX = (1 << CW) - 1;
  localparam int SMAX = (1 << (DW - 1)) - 1;
  localparam int SMIN = -(1 << (DW - 1));

  typedef struct {
    logic [NO-1:0]    v;
    logic [NO*DW-1:0] d;
    logic [NO*IW-1:0] ix;
    int               cyc;
  } beat_t;

  typedef struct {
    int cyc;
    int cnt;
  } fin_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 acc_valid;
  logic signed [AW-1:0] acc_data;
  logic                 acc_last;
  logic                 acc_ready;
  logic [NO-1:0]        out_valid;
  logic [NO*DW-1:0]     out_data;
  logic [NO*IW-1:0]     out_indices;
  logic                 ppu_finish_en;
  logic [CW-1:0]        compressed_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int low_cnt = 0;
  beat_t bq[$];
  fin_t  fq[$];

  ppu_compress #(
    .NUM_OUT(NO), .ACC_W(AW), .DATA_W(DW), .IDX_W(IW), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .acc_valid(acc_valid),
    .acc_data(acc_data),
    .acc_last(acc_last),
    .acc_ready(acc_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_indices(out_indices),
    .ppu_finish_en(ppu_finish_en),
    .compressed_count(compressed_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int ref_val(input int a);
    longint v;
    v = longint'(a);
`ifdef PPU_RELU_EN
    if (v < 0) v = 0;
`endif
    if (v > longint'(SMAX)) v = longint'(SMAX);
    if (v < longint'(SMIN)) v = longint'(SMIN);
    return int'(v);
  endfunction

  // Model: list the entries a plane should produce, then cut into beats
  task automatic send_plane(input int vals[$], input bit gaps);
    int ev[$];
    int ei[$];
    int ee[$];
    int cum[$];
    beat_t bl[$];
    int bdone[$];
    int run;
    int n;
    int c;
    int bi;
    int w;
    int n0;
    beat_t b;
    fin_t f;
    logic [DW-1:0] tv;
    logic [IW-1:0] ti;
    run = 0;
    n = vals.size();
    for (int k = 0; k < n; k++) begin
      c = ref_val(vals[k]);
      if (c != 0 || run == MAXR) begin
        ev.push_back(c);
        ei.push_back(run);
        ee.push_back(k);
        run = 0;
      end else begin
        run++;
      end
      cum.push_back(ev.size() > CMAX ? CMAX : ev.size());
    end
    for (int j = 0; j < ev.size(); j += NO) begin
      b.v = '0;
      b.d = '0;
      b.ix = '0;
      b.cyc = 0;
      for (int l = 0; l < NO; l++) begin
        if (j + l < ev.size()) begin
          tv = DW'(ev[j+l]);
          ti = IW'(ei[j+l]);
          b.v[l] = 1'b1;
          b.d[l*DW +: DW] = tv;
          b.ix[l*IW +: IW] = ti;
        end
      end
      bl.push_back(b);
      bdone.push_back((j + NO <= ev.size()) ? ee[j+NO-1] : n - 1);
    end
    bi = 0;
    for (int k = 0; k < n; k++) begin
      acc_valid = 1'b1;
      acc_data = vals[k];
      acc_last = (k == n - 1);
      w = 0;
      while (!acc_ready && w < 8) begin
        @(negedge clk);
        w++;
      end
      chk("ready_wait", 64'(acc_ready), 64'(1));
      n0 = cyc;
      @(posedge clk);
      while (bi < bl.size() && bdone[bi] == k) begin
        b = bl[bi];
        b.cyc = n0 + 1;
        bq.push_back(b);
        bi++;
      end
      if (k == n - 1) begin
        f.cyc = n0 + 2;
        f.cnt = cum[k];
        fq.push_back(f);
      end
      @(negedge clk);
      chk("count", 64'(compressed_count), 64'(cum[k]));
      if (gaps && k != n - 1 && $urandom_range(0, 3) == 0) begin
        acc_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
  endtask

  function automatic int rnd_val(input int zpct);
    int r;
    int m;
    if ($urandom_range(0, 99) < zpct) return 0;
    r = $urandom_range(0, 4);
    m = int'($urandom_range(1, 300));
    case (r)
      0: return m;
      1: return -m;
      2: return ($urandom_range(0, 1) == 1) ?
                int'($urandom_range(32768, 500000)) :
                -int'($urandom_range(32769, 500000));
      3: begin
        m = int'($urandom_range(0, 3));
        return (m == 0) ? SMAX : (m == 1) ? SMIN :
               (m == 2) ? SMAX + 1 : SMIN - 1;
      end
      default: return int'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin : mon
    beat_t b;
    fin_t f;
    if (!rst) begin
      while (bq.size() > 0 && bq[0].cyc < cyc) begin
        chk("beat_missing", 64'(cyc), 64'(bq[0].cyc));
        void'(bq.pop_front());
      end
      while (fq.size() > 0 && fq[0].cyc < cyc) begin
        chk("finish_missing", 64'(cyc), 64'(fq[0].cyc));
        void'(fq.pop_front());
      end
      if (out_valid != '0) begin
        if (bq.size() == 0) begin
          chk("beat_unexpected", 64'(out_valid), 64'(0));
        end else begin
          b = bq.pop_front();
          chk("beat_cycle", 64'(cyc), 64'(b.cyc));
          chk("beat_valid", 64'(out_valid), 64'(b.v));
          chk("beat_data", 64'(out_data), 64'(b.d));
          chk("beat_idx", 64'(out_indices), 64'(b.ix));
        end
      end
      if (ppu_finish_en) begin
        if (fq.size() == 0) begin
          chk("finish_unexpected", 64'(1), 64'(0));
        end else begin
          f = fq.pop_front();
          chk("finish_cycle", 64'(cyc), 64'(f.cyc));
          chk("finish_count", 64'(compressed_count), 64'(f.cnt));
        end
      end
      if (!acc_ready) begin
        low_cnt++;
      end else if (low_cnt > 0) begin
        chk("ready_low_len", 64'(low_cnt), 64'(2));
        low_cnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    rst = 1'b1;
    acc_valid = 1'b0;
    acc_data = '0;
    acc_last = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(acc_ready), 64'(1));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_idx", 64'(out_indices), 64'(0));
    chk("rst_finish", 64'(ppu_finish_en), 64'(0));
    chk("rst_count", 64'(compressed_count), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    q = {1, 2, 3, 4, 5, 6, 7, 8};
    send_plane(q, 1'b0);
    q = {0, 0, 5, 0, 7, 0};
    send_plane(q, 1'b0);
    q = {};
    for (int i = 0; i < 20; i++) q.push_back(0);
    q.push_back(9);
    send_plane(q, 1'b0);
    q = {-3, 70000};
    send_plane(q, 1'b0);
    q = {5};
    send_plane(q, 1'b0);
    q = {0, 0, 0};
    send_plane(q, 1'b0);

    acc_valid = 1'b0;
    repeat (4) @(negedge clk);
    acc_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      acc_data = k;
      acc_last = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    acc_valid = 1'b0;
    chk("pre_rst_count", 64'(compressed_count), 64'(3));
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_count", 64'(compressed_count), 64'(0));
    chk("arst_ready", 64'(acc_ready), 64'(1));
    chk("arst_finish", 64'(ppu_finish_en), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    q = {1, 2, 3, 4};
    send_plane(q, 1'b0);

    q = {};
    for (int i = 0; i < 1030; i++) q.push_back(i % 7 + 1);
    send_plane(q, 1'b0);

    for (int p = 0; p < 40; p++) begin
      int zp;
      q = {};
      zp = (p % 3 == 0) ? 92 : 50;
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) begin
        q.push_back(rnd_val(zp));
      end
      send_plane(q, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        acc_valid = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
      end
    end

    acc_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("beats_drained", 64'(bq.size()), 64'(0));
    chk("finish_drained", 64'(fq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
